// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin arbiter for N bus masters.
// It supports locked tenures, a one-cycle turnaround between owners and a watchdog that reclaims a hung bus.
module bus_arbiter_rr #(
  parameter int N_MASTERS = 3,
  parameter int ID_W      = 2,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = 5
) (
  input  logic                 BUS_CLK,
  input  logic                 RST,
  input  logic [N_MASTERS-1:0] BR,
  input  logic [N_MASTERS-1:0] LOCK,
  input  logic                 ACK,
  output logic [N_MASTERS-1:0] BG,
  output logic                 BUS_BUSY,
  output logic [ID_W-1:0]      GNT_ID,
  output logic                 TIMEOUT_ERR
);
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  state_t state, state_n;
  logic [ID_W-1:0] ptr, ptr_n, win, gnt_n, nxt;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N_MASTERS-1:0] bg_n;
  logic found, err_n, rel, tmo;
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = 0; i < N_MASTERS; i++)
      if (!found && BR[(int'(ptr) + i) % N_MASTERS]) begin
        found = 1'b1;
        win = ID_W'((int'(ptr) + i) % N_MASTERS);
      end
  end
  assign nxt = (int'(GNT_ID) == N_MASTERS - 1) ? '0 : GNT_ID + 1'b1;
  // Abandon and unlocked ACK both release; ACK always beats a coincident timeout.
  assign rel = !BR[GNT_ID] || (ACK && !LOCK[GNT_ID]);
  assign tmo = (TIMEOUT != 0) && !ACK && (cnt == LAST);
  assign BUS_BUSY = |BG;
  always_comb begin
    state_n = state;
    bg_n = BG;
    gnt_n = GNT_ID;
    ptr_n = ptr;
    cnt_n = cnt;
    err_n = 1'b0;
    if (state == GRANT) begin
      if (rel || tmo) begin
        state_n = TURN;
        bg_n = '0;
        ptr_n = nxt;
        err_n = !rel;
      end else begin
        cnt_n = ACK ? '0 : (&cnt ? cnt : cnt + 1'b1);
      end
    end else if (found) begin
      state_n = GRANT;
      bg_n = N_MASTERS'(1) << win;
      gnt_n = win;
      cnt_n = '0;
    end else begin
      state_n = IDLE;
      bg_n = '0;
    end
  end
  always_ff @(posedge BUS_CLK or negedge RST)
    if (!RST) begin
      state <= IDLE;
      BG <= '0;
      GNT_ID <= '0;
      ptr <= '0;
      cnt <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state <= state_n;
      BG <= bg_n;
      GNT_ID <= gnt_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      TIMEOUT_ERR <= err_n;
    end
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed and random checks of bus_arbiter_rr (N=3, T=8)
// against a tenure-level model that tracks the owner, the pointer and the wait count.
module tb_bus_arbiter_rr;
  localparam int N = 3;
  localparam int T = 8;
  logic clk = 1'b0, rst_n = 1'b0, ack = 1'b0;
  logic [N-1:0] br = '0, lock = '0, bg;
  logic busy, terr;
  logic [1:0] gnt;
  int n_cmp = 0, n_err = 0;
  int m_own = -1, m_ptr = 0, m_cnt = 0, m_gnt = 0;
  bit m_err = 1'b0;

  bus_arbiter_rr #(.N_MASTERS(N), .ID_W(2), .TIMEOUT(T), .CNT_W(5)) dut (
    .BUS_CLK(clk), .RST(rst_n), .BR(br), .LOCK(lock), .ACK(ack),
    .BG(bg), .BUS_BUSY(busy), .GNT_ID(gnt), .TIMEOUT_ERR(terr)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_from(int p, logic [N-1:0] r);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_cnt = 0; m_gnt = 0; m_err = 1'b0;
  endtask

  task automatic step();
    int w, nown, nptr, ncnt, ngnt;
    bit nerr;
    nown = m_own; nptr = m_ptr; ncnt = m_cnt; ngnt = m_gnt; nerr = 1'b0;
    if (m_own < 0) begin
      w = first_from(m_ptr, br);
      if (w >= 0) begin nown = w; ngnt = w; ncnt = 0; end
    end else begin
      w = m_own;
      if (!br[w] || (ack && !lock[w])) begin nown = -1; nptr = (w + 1) % N; end
      else if (ack) ncnt = 0;
      else if (m_cnt == T - 1) begin nown = -1; nptr = (w + 1) % N; nerr = 1'b1; end
      else ncnt = m_cnt + 1;
    end
    @(posedge clk);
    #1;
    m_own = nown; m_ptr = nptr; m_cnt = ncnt; m_gnt = ngnt; m_err = nerr;
    chk("model_bg", 32'(bg), (m_own < 0) ? 32'd0 : (32'd1 << m_own));
    chk("model_busy", 32'(busy), 32'(m_own >= 0));
    chk("model_gnt_id", 32'(gnt), 32'(m_gnt));
    chk("model_timeout_err", 32'(terr), 32'(m_err));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; br = '0; lock = '0; ack = 1'b0;
    model_reset();
    #20;
    rst_n = 1'b1;
  endtask

  initial begin
    #6;
    chk("reset_bg", 32'(bg), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_gnt_id", 32'(gnt), 32'd0);
    chk("reset_terr", 32'(terr), 32'd0);
    do_reset();

    br = 3'b010;
    step();
    chk("single_bg", 32'(bg), 32'h2);
    chk("single_gnt", 32'(gnt), 32'd1);
    repeat (3) step();
    ack = 1'b1;
    step();
    chk("single_release", 32'(bg), 32'd0);
    ack = 1'b0; br = '0;
    step();
    chk("single_idle", 32'(bg), 32'd0);

    do_reset();
    br = 3'b111;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("fair_gnt", 32'(gnt), 32'(k % N));
      chk("fair_bg", 32'(bg), 32'd1 << (k % N));
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("fair_turn", 32'(bg), 32'd0);
    end

    do_reset();
    br = 3'b100; lock = 3'b100;
    step();
    chk("lock_grant", 32'(bg), 32'h4);
    br = 3'b111;
    repeat (3) begin
      ack = 1'b1;
      step();
      chk("lock_hold_ack", 32'(bg), 32'h4);
      ack = 1'b0;
      step();
      chk("lock_hold", 32'(bg), 32'h4);
    end
    lock = '0; ack = 1'b1;
    step();
    chk("lock_release", 32'(bg), 32'd0);
    ack = 1'b0; br = 3'b011;
    step();
    chk("lock_next", 32'(bg), 32'h1);

    do_reset();
    br = 3'b010;
    step();
    for (int i = 1; i < T; i++) begin
      step();
      chk("wd_hold", 32'(bg), 32'h2);
      chk("wd_no_err", 32'(terr), 32'd0);
    end
    step();
    chk("wd_drop", 32'(bg), 32'd0);
    chk("wd_err", 32'(terr), 32'd1);
    chk("wd_gnt", 32'(gnt), 32'd1);
    br = 3'b111;
    step();
    chk("wd_err_pulse", 32'(terr), 32'd0);
    chk("wd_ptr", 32'(bg), 32'h4);
    br = 3'b011;
    step();
    chk("abandon_bg", 32'(bg), 32'd0);
    chk("abandon_err", 32'(terr), 32'd0);
    br = '0;
    step();

    do_reset();
    br = 3'b001;
    step();
    repeat (T - 1) step();
    ack = 1'b1;
    step();
    chk("ack_tmo_bg", 32'(bg), 32'd0);
    chk("ack_tmo_err", 32'(terr), 32'd0);
    ack = 1'b0; br = '0;
    step();
    chk("ack_tmo_err2", 32'(terr), 32'd0);

    do_reset();
    br = 3'b010;
    step();
    ack = 1'b1;
    step();
    ack = 1'b0; br = 3'b100;
    step();
    chk("async_pre", 32'(bg), 32'h4);
    #3 rst_n = 1'b0;
    #1;
    chk("async_bg", 32'(bg), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    br = 3'b110;
    step();
    chk("async_ptr", 32'(bg), 32'h2);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) br = N'($urandom_range(0, 7));
      lock = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 7)) : '0;
      ack = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
